fetch_ctrl: RTL
===============

# fetch_ctrl

Instruction-fetch controller for the MIPS pipeline. Owns the program counter that addresses the instruction memory, and selects the next PC from four sources: sequential, branch/jump, exception entry and `eret`. Runs a short boot hold after reset and detects fetch address errors (AdEL). Sits between the IM (combinational read, base 0x00003000, handler image at 0x00004180) and the IF/ID pipeline register, under control of the hazard unit and CP0.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000, first fetch address after reset; also the IM base.
- `HANDLER_PC`, 32'h0000_4180, exception entry address.
- `IM_WORDS`, 4096, IM depth in words; the legal fetch window is [RESET_PC, RESET_PC+4*IM_WORDS-4].
- `BOOT_CYCLES`, 2, number of cycles held in BOOT after reset; minimum 1.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `stall`  in  1  hazard unit freeze of IF/ID.
- `br_taken`  in  1  branch/jump resolved taken in ID.
- `br_target`  in  32  branch/jump target.
- `exc_req`  in  1  CP0 exception/interrupt entry.
- `eret`  in  1  CP0 exception return.
- `epc`  in  32  return address for `eret`.
- `instr_in`  in  32  word read from the IM at `pc`.
- `pc`  out  32  registered fetch address, driven to the IM address input.
- `instr_out`  out  32  instruction to IF/ID; forced to 0 (nop) when `if_valid`=0.
- `if_valid`  out  1  `instr_out` is a real fetched instruction.
- `adel`  out  1  fetch address error at the current `pc`.
- `fetch_cnt`  out  32  count of instructions accepted into IF/ID.

## Operation
- FSM states: BOOT, RUN, FAULT.
- `illegal` = `pc[1:0]`≠0, or `pc` < RESET_PC, or `pc` > RESET_PC+4*IM_WORDS-4. Comparisons are 32-bit unsigned.
- BOOT:
  - `pc` is held at RESET_PC; `if_valid`=0; `adel`=0.
  - `boot_cnt` increments each cycle. When `boot_cnt`=BOOT_CYCLES-1, the next state is RUN.
  - `stall`, `br_taken`, `exc_req` and `eret` are ignored.
- RUN. The next PC is chosen by strict priority:
  1. `exc_req`: HANDLER_PC.
  2. `eret`: `epc`, passed through unmodified (a misaligned `epc` faults afterwards).
  3. `illegal`: `pc` is held and the next state is FAULT.
  4. `br_taken` & !`stall`: `br_target`.
  5. `stall`: `pc` is held. `br_taken` is ignored while `stall`=1; the ID stage re-presents it.
  6. Otherwise `pc`+4, modulo 2^32.
- FAULT:
  - `pc` is held; `adel`=1; `if_valid`=0.
  - `exc_req` loads HANDLER_PC and the next state is RUN. `exc_req` outranks `eret`.
  - Otherwise `eret` loads `epc` and the next state is RUN.
  - `stall` and `br_taken` are ignored.
- Output equations:
  - `if_valid` = (state==RUN) & !`illegal`.
  - `adel` = (state!=BOOT) & `illegal`.
  - `instr_out` = `if_valid` ? `instr_in` : 0.
- `fetch_cnt` increments when `if_valid` & !`stall` & !`exc_req` & !`eret`, and wraps from 0xFFFF_FFFF to 0.

## Timing
- Reset values: state=BOOT, `pc`=RESET_PC, `boot_cnt`=0, `fetch_cnt`=0. Resulting outputs: `if_valid`=0, `adel`=0, `instr_out`=0.
- First valid fetch appears BOOT_CYCLES cycles after `reset` deasserts, at `pc`=RESET_PC.
- Redirect latency is 1 cycle: a source sampled at edge N sets `pc` after edge N; `instr_out` for the new `pc` is valid in the same cycle because the IM read is combinational.
- `adel` asserts combinationally in the same cycle `pc` becomes illegal. FAULT is entered at the next edge unless `exc_req` or `eret` is asserted in that cycle.
- `reset` in any state or cycle overrides all inputs and restarts BOOT.
- Simultaneous `exc_req` and `eret`: `exc_req` wins.
- `exc_req` or `eret` together with `stall`: the redirect still happens.

## Structure
- Shared `mips_defs` package/header holds: RESET_PC, HANDLER_PC, IM_WORDS, the FSM state encodings (2 bits) and the NOP encoding 32'h0.
- One natural sub-module, `pc_next_mux`: the combinational priority selector for the next PC. The FSM, boot counter and fetch counter stay in `fetch_ctrl`.
- Not synthesizing a separate incrementer beyond `pc`+4.

## Test plan
- Reset then release, BOOT_CYCLES=2, IM word0=0x3C010001 -> `if_valid`=0 for 2 cycles; then `pc`=0x3000, `instr_out`=0x3C010001, next `pc`=0x3004.
- `stall`=1 for 3 cycles at `pc`=0x3008 with `br_taken`=1, `br_target`=0x3100 -> `pc` stays 0x3008 and `fetch_cnt` is unchanged; after `stall` drops with `br_taken`=1, `pc`=0x3100.
- `exc_req`=1 and `eret`=1 together at `pc`=0x3010 -> `pc`=0x4180 next cycle, `instr_out`=IM word 1120.
- `eret` with `epc`=0x3002 -> `pc`=0x3002, `adel`=1 in that cycle, `instr_out`=0; state FAULT on the next edge. `br_taken` in FAULT is ignored; `exc_req` -> `pc`=0x4180, RUN.
- Sequential fetch reaching 0x6FFC -> the next `pc`=0x7000 asserts `adel`, and `fetch_cnt` equals the number of valid unstalled fetches.
- `reset` asserted in FAULT and during RUN with `stall`=1 -> `pc`=0x3000, `fetch_cnt`=0, BOOT re-entered.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS fetch definitions: memory map, FSM encodings and the nop word.
package mips_defs;

  localparam logic [31:0] MIPS_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] MIPS_HANDLER_PC = 32'h0000_4180;
  localparam int          MIPS_IM_WORDS   = 4096;
  localparam logic [31:0] MIPS_NOP        = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_pc_next_mux.sv
// Priority selector for the next fetch address, given the current FSM state.
module pc_next_mux
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC   = MIPS_RESET_PC,
  parameter logic [31:0] HANDLER_PC = MIPS_HANDLER_PC
) (
  input  fetch_state_e state,
  input  logic [31:0]  pc,
  input  logic         illegal,
  input  logic         stall,
  input  logic         br_taken,
  input  logic [31:0]  br_target,
  input  logic         exc_req,
  input  logic         eret,
  input  logic [31:0]  epc,
  output logic [31:0]  pc_next
);

  // Exception entry outranks eret everywhere; BOOT pins the PC to the reset vector.
  always_comb begin
    pc_next = pc;
    unique case (state)
      ST_BOOT: pc_next = RESET_PC;
      ST_RUN: begin
        if (exc_req)                  pc_next = HANDLER_PC;
        else if (eret)                pc_next = epc;
        else if (illegal)             pc_next = pc;
        else if (br_taken && !stall)  pc_next = br_target;
        else if (stall)               pc_next = pc;
        else                          pc_next = pc + 32'd4;
      end
      ST_FAULT: begin
        if (exc_req)   pc_next = HANDLER_PC;
        else if (eret) pc_next = epc;
        else           pc_next = pc;
      end
      default: pc_next = RESET_PC;
    endcase
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, boot hold, AdEL detection and fetch count.
module fetch_ctrl
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC    = MIPS_RESET_PC,
  parameter logic [31:0] HANDLER_PC  = MIPS_HANDLER_PC,
  parameter int          IM_WORDS    = MIPS_IM_WORDS,
  parameter int          BOOT_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         br_taken,
  input  logic [31:0]  br_target,
  input  logic         exc_req,
  input  logic         eret,
  input  logic [31:0]  epc,
  input  logic [31:0]  instr_in,
  output logic [31:0]  pc,
  output logic [31:0]  instr_out,
  output logic         if_valid,
  output logic         adel,
  output logic [31:0]  fetch_cnt,
  output fetch_state_e state_dbg
);

  // Highest word address that still lies inside the IM image.
  localparam logic [31:0] LAST_PC = RESET_PC + 32'(4 * IM_WORDS) - 32'd4;
  localparam int          BW      = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [BW-1:0] boot_cnt_q, boot_cnt_d;
  logic [31:0]   fetch_cnt_q, fetch_cnt_d;
  logic          illegal;

  // Address error: misaligned or outside the IM window (unsigned compares).
  always_comb begin
    illegal = (pc_q[1:0] != 2'b00) || (pc_q < RESET_PC) || (pc_q > LAST_PC);
  end

  pc_next_mux #(
    .RESET_PC   (RESET_PC),
    .HANDLER_PC (HANDLER_PC)
  ) u_pc_next_mux (
    .state     (state_q),
    .pc        (pc_q),
    .illegal   (illegal),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .exc_req   (exc_req),
    .eret      (eret),
    .epc       (epc),
    .pc_next   (pc_d)
  );

  // Next-state, boot counter, fetch counter and output equations.
  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    fetch_cnt_d = fetch_cnt_q;
    if_valid    = (state_q == ST_RUN) && !illegal;
    adel        = (state_q != ST_BOOT) && illegal;
    instr_out   = if_valid ? instr_in : MIPS_NOP;

    unique case (state_q)
      ST_BOOT: begin
        boot_cnt_d = boot_cnt_q + BW'(1);
        if (boot_cnt_q == BOOT_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        // A redirect in the same cycle as an illegal PC escapes FAULT.
        if (!exc_req && !eret && illegal) state_d = ST_FAULT;
      end
      ST_FAULT: begin
        if (exc_req || eret) state_d = ST_RUN;
      end
      default: state_d = ST_BOOT;
    endcase

    if (if_valid && !stall && !exc_req && !eret) fetch_cnt_d = fetch_cnt_q + 32'd1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      boot_cnt_q  <= '0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      boot_cnt_q  <= boot_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign pc        = pc_q;
  assign fetch_cnt = fetch_cnt_q;
  assign state_dbg = state_q;

endmodule
